// File: rtl/fb_port_arbiter_if.sv
// Frame-buffer arbiter bus: display read, camera write, RAM port.
// ovf_cnt exists only when FB_OVF_CNT_EN is defined.
interface fb_port_arbiter_if #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 12,
  parameter int FIFO_AW = 4
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [FIFO_AW:0]  fifo_level;
  logic              wr_drop;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef FB_OVF_CNT_EN
  logic [15:0]       ovf_cnt;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr,
    output wr_data, mem_rdata,
    input  rd_data, rd_valid, wr_ready,
    input  fifo_level, wr_drop, mem_en, mem_we,
    input  mem_addr, mem_wdata, ovf_cnt
  );
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr,
    input  wr_data, mem_rdata,
    output rd_data, rd_valid, wr_ready,
    output fifo_level, wr_drop, mem_en, mem_we,
    output mem_addr, mem_wdata, ovf_cnt
  );
`else
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr,
    output wr_data, mem_rdata,
    input  rd_data, rd_valid, wr_ready,
    input  fifo_level, wr_drop, mem_en, mem_we,
    input  mem_addr, mem_wdata
  );
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr,
    input  wr_data, mem_rdata,
    output rd_data, rd_valid, wr_ready,
    output fifo_level, wr_drop, mem_en, mem_we,
    output mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: display reads win, camera writes queue.
// Define FB_OVF_CNT_EN to add the saturating ovf_cnt drop counter.
module fb_port_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 12,
  parameter int FB_WORDS = 307200,
  parameter int FIFO_AW  = 4
) (
  input  logic vga_clk,
  input  logic sys_rst,
  fb_port_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;

  logic [ADDR_W-1:0] fa_q [DEPTH];
  logic [DATA_W-1:0] fd_q [DEPTH];
  logic [FIFO_AW:0]  wptr_q, rptr_q;
  logic [FIFO_AW:0]  lvl_q, lvl_d;
  logic              rd_valid_q;
  logic              drop_q;

  logic full, empty, in_range;
  logic push, pop, drop;
  logic rd_gnt, wr_gnt;

  assign empty = (wptr_q == rptr_q);
  assign full  =
    (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
    (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign in_range = bus.wr_addr < ADDR_W'(FB_WORDS);

  assign rd_gnt = !sys_rst && bus.rd_req;
  assign wr_gnt = !sys_rst && !bus.rd_req && !empty;
  assign pop    = wr_gnt;
  assign push   = !sys_rst && bus.wr_req &&
                  !full && in_range;
  assign drop   = !sys_rst && bus.wr_req &&
                  (full || !in_range);

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      rd_gnt: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.rd_addr;
      end
      wr_gnt: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = fa_q[rptr_q[FIFO_AW-1:0]];
        bus.mem_wdata = fd_q[rptr_q[FIFO_AW-1:0]];
      end
      default: ;
    endcase
  end

  always_comb begin
    lvl_d = lvl_q;
    unique case ({push, pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      lvl_q      <= '0;
      rd_valid_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      lvl_q      <= lvl_d;
      rd_valid_q <= bus.rd_req;
      drop_q     <= drop;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge vga_clk) begin
    if (push) begin
      fa_q[wptr_q[FIFO_AW-1:0]] <= bus.wr_addr;
      fd_q[wptr_q[FIFO_AW-1:0]] <= bus.wr_data;
    end
  end

  assign bus.rd_data    = bus.mem_rdata;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.wr_ready   = !sys_rst && !full;
  assign bus.fifo_level = lvl_q;
  assign bus.wr_drop    = drop_q;

`ifdef FB_OVF_CNT_EN
  logic [15:0] ovf_q;

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      ovf_q <= '0;
    end else if (drop && (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 1'b1;
    end
  end

  assign bus.ovf_cnt = ovf_q;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter.
// ovf_cnt checks compile in only with FB_OVF_CNT_EN.
module tb_fb_port_arbiter;
  logic vga_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   n_cmp   = 0;
  int   n_err   = 0;

  always #5 vga_clk = ~vga_clk;

  fb_port_arbiter_if bus ();

  fb_port_arbiter dut (
    .vga_clk (vga_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  function automatic logic [11:0] ram_f(
    input logic [18:0] a
  );
    return a[11:0] ^ 12'h5A5;
  endfunction

  // Synchronous RAM stub, read path only.
  always @(posedge vga_clk)
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= ram_f(bus.mem_addr);

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic idle_in();
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
  endtask

  task automatic test_reset();
    sys_rst     = 1'b1;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 19'd3;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 19'd9;
    #1;
    n_cmp++;
    if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mem en=%b we=%b exp 0/0",
               bus.mem_en, bus.mem_we);
    end
    n_cmp++;
    if (bus.wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ready got %b exp 0", bus.wr_ready);
    end
    tick();
    sys_rst = 1'b0;
    idle_in();
    #1;
    n_cmp++;
    if (bus.mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL idle_en got %b exp 0", bus.mem_en);
    end
    n_cmp++;
    if (bus.fifo_level !== 5'd0) begin
      n_err++;
      $display("FAIL idle_lvl got %0d exp 0", bus.fifo_level);
    end
    n_cmp++;
    if (bus.wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_ready got %b exp 1", bus.wr_ready);
    end
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.wr_drop !== 1'b0) begin
      n_err++;
      $display("FAIL idle_flags rv=%b drop=%b exp 0/0",
               bus.rd_valid, bus.wr_drop);
    end
`ifdef FB_OVF_CNT_EN
    n_cmp++;
    if (bus.ovf_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rst_ovf got %0d exp 0", bus.ovf_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_single_write();
    bus.wr_req  = 1'b1;
    bus.wr_addr = 19'd5;
    bus.wr_data = 12'hABC;
    #1;
    tick();
    bus.wr_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_we !== 1'b1 || bus.mem_en !== 1'b1) begin
      n_err++;
      $display("FAIL wr1_we en=%b we=%b exp 1/1",
               bus.mem_en, bus.mem_we);
    end
    n_cmp++;
    if (bus.mem_addr !== 19'd5 ||
        bus.mem_wdata !== 12'hABC) begin
      n_err++;
      $display("FAIL wr1_bus a=%0d d=%h exp 5/abc",
               bus.mem_addr, bus.mem_wdata);
    end
    n_cmp++;
    if (bus.fifo_level !== 5'd1) begin
      n_err++;
      $display("FAIL wr1_lvl1 got %0d exp 1", bus.fifo_level);
    end
    tick();
    #1;
    n_cmp++;
    if (bus.fifo_level !== 5'd0 || bus.mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL wr1_lvl0 lvl=%0d en=%b exp 0/0",
               bus.fifo_level, bus.mem_en);
    end
    tick();
  endtask

  task automatic test_read_burst();
    int drops = 0;
    logic [18:0] pa = '0;
    for (int k = 0; k < 640; k++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = 19'(k * 7);
      bus.wr_req  = (k < 20);
      bus.wr_addr = 19'(100 + k);
      bus.wr_data = 12'(256 + k);
      #1;
      n_cmp++;
      if (bus.mem_we !== 1'b0 ||
          bus.mem_addr !== bus.rd_addr) begin
        n_err++;
        $display("FAIL burst_rd k=%0d we=%b a=%0d exp 0/%0d",
                 k, bus.mem_we, bus.mem_addr, k * 7);
      end
      n_cmp++;
      if (bus.rd_valid !== (k > 0)) begin
        n_err++;
        $display("FAIL burst_rv k=%0d got %b", k, bus.rd_valid);
      end
      if (k > 0) begin
        n_cmp++;
        if (bus.rd_data !== ram_f(pa)) begin
          n_err++;
          $display("FAIL burst_rdata k=%0d got %h exp %h",
                   k, bus.rd_data, ram_f(pa));
        end
      end
      if (bus.wr_drop === 1'b1) drops++;
      pa = bus.rd_addr;
      tick();
    end
    idle_in();
    n_cmp++;
    if (drops != 4) begin
      n_err++;
      $display("FAIL burst_drops got %0d exp 4", drops);
    end
    for (int j = 0; j < 16; j++) begin
      #1;
      n_cmp++;
      if (bus.mem_we !== 1'b1 ||
          bus.mem_addr !== 19'(100 + j) ||
          bus.mem_wdata !== 12'(256 + j)) begin
        n_err++;
        $display("FAIL drain j=%0d we=%b a=%0d d=%h",
                 j, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      if (j == 0) begin
        n_cmp++;
        if (bus.rd_valid !== 1'b1 ||
            bus.rd_data !== ram_f(19'd4473)) begin
          n_err++;
          $display("FAIL drain_rv rv=%b d=%h exp 1/%h",
                   bus.rd_valid, bus.rd_data, ram_f(19'd4473));
        end
      end
      tick();
    end
    #1;
    n_cmp++;
    if (bus.mem_en !== 1'b0 || bus.fifo_level !== 5'd0 ||
        bus.rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_end en=%b lvl=%0d rv=%b",
               bus.mem_en, bus.fifo_level, bus.rd_valid);
    end
`ifdef FB_OVF_CNT_EN
    n_cmp++;
    if (bus.ovf_cnt !== 16'd4) begin
      n_err++;
      $display("FAIL burst_ovf got %0d exp 4", bus.ovf_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_out_of_range();
    bus.wr_req  = 1'b1;
    bus.wr_addr = 19'd307200;
    bus.wr_data = 12'h111;
    #1;
    tick();
    bus.wr_addr = 19'd307199;
    bus.wr_data = 12'h222;
    #1;
    n_cmp++;
    if (bus.wr_drop !== 1'b1 || bus.fifo_level !== 5'd0 ||
        bus.mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL oor_drop drop=%b lvl=%0d en=%b exp 1/0/0",
               bus.wr_drop, bus.fifo_level, bus.mem_en);
    end
    tick();
    bus.wr_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.wr_drop !== 1'b0 || bus.fifo_level !== 5'd1 ||
        bus.mem_we !== 1'b1 ||
        bus.mem_addr !== 19'd307199) begin
      n_err++;
      $display("FAIL oor_edge drop=%b lvl=%0d we=%b a=%0d",
               bus.wr_drop, bus.fifo_level,
               bus.mem_we, bus.mem_addr);
    end
    tick();
    #1;
`ifdef FB_OVF_CNT_EN
    n_cmp++;
    if (bus.ovf_cnt !== 16'd5) begin
      n_err++;
      $display("FAIL oor_ovf got %0d exp 5", bus.ovf_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_full_pop();
    for (int k = 0; k < 16; k++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = 19'd1;
      bus.wr_req  = 1'b1;
      bus.wr_addr = 19'(200 + k);
      bus.wr_data = 12'(k);
      #1;
      tick();
    end
    bus.rd_req  = 1'b0;
    bus.wr_addr = 19'd7;
    bus.wr_data = 12'hFFF;
    #1;
    n_cmp++;
    if (bus.wr_ready !== 1'b0 || bus.fifo_level !== 5'd16) begin
      n_err++;
      $display("FAIL full_state rdy=%b lvl=%0d exp 0/16",
               bus.wr_ready, bus.fifo_level);
    end
    n_cmp++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 19'd200) begin
      n_err++;
      $display("FAIL full_pop we=%b a=%0d exp 1/200",
               bus.mem_we, bus.mem_addr);
    end
    tick();
    bus.wr_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.wr_drop !== 1'b1 || bus.fifo_level !== 5'd15) begin
      n_err++;
      $display("FAIL full_drop drop=%b lvl=%0d exp 1/15",
               bus.wr_drop, bus.fifo_level);
    end
    for (int j = 1; j < 16; j++) begin
      if (j > 1) #1;
      n_cmp++;
      if (bus.mem_we !== 1'b1 ||
          bus.mem_addr !== 19'(200 + j)) begin
        n_err++;
        $display("FAIL full_drain j=%0d we=%b a=%0d",
                 j, bus.mem_we, bus.mem_addr);
      end
      tick();
    end
    #1;
    n_cmp++;
    if (bus.fifo_level !== 5'd0 || bus.mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL full_end lvl=%0d en=%b exp 0/0",
               bus.fifo_level, bus.mem_en);
    end
`ifdef FB_OVF_CNT_EN
    n_cmp++;
    if (bus.ovf_cnt !== 16'd6) begin
      n_err++;
      $display("FAIL full_ovf got %0d exp 6", bus.ovf_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = 19'd2;
      bus.wr_req  = 1'b1;
      bus.wr_addr = 19'(300 + k);
      bus.wr_data = 12'(k);
      #1;
      tick();
    end
    idle_in();
    sys_rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.fifo_level !== 5'd8) begin
      n_err++;
      $display("FAIL mid_lvl8 got %0d exp 8", bus.fifo_level);
    end
    n_cmp++;
    if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst en=%b we=%b exp 0/0",
               bus.mem_en, bus.mem_we);
    end
    tick();
    sys_rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      #1;
      n_cmp++;
      if (bus.mem_we !== 1'b0 || bus.fifo_level !== 5'd0) begin
        n_err++;
        $display("FAIL mid_stale j=%0d we=%b lvl=%0d",
                 j, bus.mem_we, bus.fifo_level);
      end
`ifdef FB_OVF_CNT_EN
      if (j == 0) begin
        n_cmp++;
        if (bus.ovf_cnt !== 16'd0) begin
          n_err++;
          $display("FAIL mid_ovf got %0d exp 0", bus.ovf_cnt);
        end
      end
`endif
      tick();
    end
  endtask

  initial begin
    idle_in();
    @(posedge vga_clk);
    #1;
    test_reset();
    test_single_write();
    test_read_burst();
    test_out_of_range();
    test_full_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
